// File: rtl/vec_wb_arbiter.sv
// vec_wb_arbiter: round-robin write-back arbiter for the vector RF write port, with LMUL group legality check.
// Define VEC_WB_STATS_EN to add saturating write/error statistics counters.
module vec_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int MAX_VLEN   = 4096,
    parameter int DATA_WIDTH = MAX_VLEN,
    parameter int NUM_VREGS  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  exe_valid,
    output logic                  exe_ready,
    input  logic [ADDR_WIDTH-1:0] exe_waddr,
    input  logic [DATA_WIDTH-1:0] exe_wdata,
    input  logic [3:0]            exe_lmul,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_waddr,
    input  logic [DATA_WIDTH-1:0] lsu_wdata,
    input  logic [3:0]            lsu_lmul,
    output logic                  rf_wr_en,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic [3:0]            rf_lmul,
    output logic                  err_valid,
    output logic                  err_src,
    output logic                  busy
`ifdef VEC_WB_STATS_EN
    ,
    output logic [15:0]           stat_exe_wr,
    output logic [15:0]           stat_lsu_wr,
    output logic [15:0]           stat_err
`endif
);
    typedef enum logic {IDLE, WRITE} state_e;

    localparam logic [ADDR_WIDTH:0] VREG_LIM = (ADDR_WIDTH+1)'(NUM_VREGS);

    state_e                state_q, state_d;
    logic [1:0]            full_q, full_d;
    logic [ADDR_WIDTH-1:0] addr_q [2];
    logic [ADDR_WIDTH-1:0] addr_d [2];
    logic [DATA_WIDTH-1:0] data_q [2];
    logic [DATA_WIDTH-1:0] data_d [2];
    logic [3:0]            lmul_q [2];
    logic [3:0]            lmul_d [2];
    logic                  ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
    logic [3:0]            rf_lmul_q, rf_lmul_d;
    logic                  err_q, err_d, err_src_q, err_src_d;

    logic [1:0]            in_valid;
    logic [ADDR_WIDTH-1:0] in_addr [2];
    logic [DATA_WIDTH-1:0] in_data [2];
    logic [3:0]            in_lmul [2];

    logic                  any_full, win, legal, issue_ok;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [3:0]            sel_lmul;

    assign in_valid   = {lsu_valid, exe_valid};
    assign in_addr[0] = exe_waddr;
    assign in_addr[1] = lsu_waddr;
    assign in_data[0] = exe_wdata;
    assign in_data[1] = lsu_wdata;
    assign in_lmul[0] = exe_lmul;
    assign in_lmul[1] = lsu_lmul;

    always_comb begin
        any_full   = |full_q;
        win        = &full_q ? ptr_q : full_q[1];
        sel_addr   = addr_q[win];
        sel_lmul   = lmul_q[win];
        // lmul is a power of two once the first term holds, so lmul-1 is the alignment mask
        legal      = (sel_lmul inside {4'd1, 4'd2, 4'd4, 4'd8})
                  && ((sel_addr & ADDR_WIDTH'(sel_lmul - 4'd1)) == '0)
                  && (({1'b0, sel_addr} + (ADDR_WIDTH+1)'(sel_lmul)) <= VREG_LIM);
        issue_ok   = any_full && legal;
        err_d      = any_full && !legal;
        state_d    = issue_ok ? WRITE : IDLE;
        ptr_d      = any_full ? ~win : ptr_q;
        rf_waddr_d = issue_ok ? sel_addr : rf_waddr_q;
        rf_wdata_d = issue_ok ? data_q[win] : rf_wdata_q;
        rf_lmul_d  = issue_ok ? sel_lmul : rf_lmul_q;
        err_src_d  = err_d ? win : err_src_q;
        for (int i = 0; i < 2; i++) begin
            full_d[i] = (full_q[i] && !(any_full && win == 1'(i))) || (in_valid[i] && !full_q[i]);
            addr_d[i] = (in_valid[i] && !full_q[i]) ? in_addr[i] : addr_q[i];
            data_d[i] = (in_valid[i] && !full_q[i]) ? in_data[i] : data_q[i];
            lmul_d[i] = (in_valid[i] && !full_q[i]) ? in_lmul[i] : lmul_q[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            full_q     <= '0;
            ptr_q      <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            rf_lmul_q  <= 4'd1;
            err_q      <= 1'b0;
            err_src_q  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                lmul_q[i] <= 4'd1;
            end
        end else begin
            state_q    <= state_d;
            full_q     <= full_d;
            ptr_q      <= ptr_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            rf_lmul_q  <= rf_lmul_d;
            err_q      <= err_d;
            err_src_q  <= err_src_d;
            for (int i = 0; i < 2; i++) begin
                addr_q[i] <= addr_d[i];
                data_q[i] <= data_d[i];
                lmul_q[i] <= lmul_d[i];
            end
        end
    end

    assign exe_ready = !full_q[0];
    assign lsu_ready = !full_q[1];
    assign rf_wr_en  = state_q == WRITE;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign rf_lmul   = rf_lmul_q;
    assign err_valid = err_q;
    assign err_src   = err_src_q;
    assign busy      = |full_q || rf_wr_en;

`ifdef VEC_WB_STATS_EN
    logic [15:0] st_exe_q, st_lsu_q, st_err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_exe_q <= '0;
            st_lsu_q <= '0;
            st_err_q <= '0;
        end else begin
            st_exe_q <= st_exe_q + 16'(issue_ok && !win && st_exe_q != 16'hFFFF);
            st_lsu_q <= st_lsu_q + 16'(issue_ok && win && st_lsu_q != 16'hFFFF);
            st_err_q <= st_err_q + 16'(err_d && st_err_q != 16'hFFFF);
        end
    end

    assign stat_exe_wr = st_exe_q;
    assign stat_lsu_wr = st_lsu_q;
    assign stat_err    = st_err_q;
`endif
endmodule
